// File: rtl/crypto_round_sequencer.sv
// ---------------------------------------------------------------------------
// crypto_round_sequencer
//
// Purpose:
//   Multi-cycle controller that steps a combinational 32-bit crypto round
//   core through NUM_ROUNDS rounds. Each round's core output is fed back as
//   the next round's rs1. The block sits between the CPU custom-instruction
//   issue logic and the round core.
//
// Handshakes (valid/ready semantics):
//   Request : a request transfers on a rising edge where start && ready.
//             ready is high only in IDLE; start is ignored otherwise.
//   Result  : a result transfers on a rising edge where
//             result_valid && result_ready. result_valid is high only in
//             DONE and, once high, stays high with result stable until the
//             transfer (or an abort / reset).
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   start, rs1, rs2, sel  request strobe and operands (sel: 0 enc, 1 dec)
//   ready                 request may be accepted (IDLE)
//   busy                  operation in flight or result pending (RUN/DONE)
//   result, result_valid  final round output and its valid flag
//   result_ready          consumer acknowledge for result
//   core_rs1/rs2/count/sel  registered drive to the round core
//   core_rd               round core output (combinational, same cycle)
//   abort                 early exit from RUN/DONE (CRYPTO_ABORT_EN only)
//   dbg_state_o           current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Build option:
//   CRYPTO_ABORT_EN  - when defined, adds the abort input.
// ---------------------------------------------------------------------------
module crypto_round_sequencer #(
    parameter int NUM_ROUNDS = 4,
    parameter int DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic              sel,
`ifdef CRYPTO_ABORT_EN
    input  logic              abort,
`endif
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] core_rs1,
    output logic [DATA_W-1:0] core_rs2,
    output logic [1:0]        core_count,
    output logic              core_sel,
    input  logic [DATA_W-1:0] core_rd,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    // Decrypt count for round r is (NUM_ROUNDS-1-r) mod 4; only the low two
    // bits of the subtraction matter, so the arithmetic is done in 2 bits.
    localparam logic [1:0] LAST_CNT   = 2'(NUM_ROUNDS - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              sel_q, sel_d;
    logic [3:0]        round_q, round_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        round_inc;
    logic              abort_w;
    logic              last_round;

`ifdef CRYPTO_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_round = (round_q == LAST_ROUND);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. Abort wins over completion and acknowledge.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort_w)         state_d = ST_IDLE;
                else if (last_round) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (abort_w)           state_d = ST_IDLE;
                else if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        ready        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  busy  = 1'b1;
            ST_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state. The core count is precomputed one edge ahead so
    // that core_count comes straight from a flop like the other core inputs.
    // An aborted RUN cycle leaves data/round untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        key_d     = key_q;
        sel_d     = sel_q;
        round_d   = round_q;
        count_d   = count_q;
        result_d  = result_q;
        round_inc = round_q + 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = rs1;
                    key_d   = rs2;
                    sel_d   = sel;
                    round_d = 4'd0;
                    count_d = sel ? LAST_CNT : 2'd0;
                end
            end
            ST_RUN: begin
                if (!abort_w) begin
                    data_d = core_rd;
                    if (last_round) begin
                        // round stays at NUM_ROUNDS-1 so count holds its last value
                        result_d = core_rd;
                    end else begin
                        round_d = round_inc;
                        count_d = sel_q ? (LAST_CNT - round_inc[1:0]) : round_inc[1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q   <= '0;
            key_q    <= '0;
            sel_q    <= 1'b0;
            round_q  <= 4'd0;
            count_q  <= 2'd0;
            result_q <= '0;
        end else begin
            data_q   <= data_d;
            key_q    <= key_d;
            sel_q    <= sel_d;
            round_q  <= round_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign result      = result_q;
    assign core_rs1    = data_q;
    assign core_rs2    = key_q;
    assign core_sel    = sel_q;
    assign core_count  = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crypto_round_sequencer
//
// Self-checking bench for crypto_round_sequencer (NUM_ROUNDS=4, DATA_W=32)
// with a stub round core: core_rd = (core_rs1 ^ core_rs2) + core_count.
// Expected results are pushed to exp_q when a request is accepted and popped
// when the DUT presents a valid result.
// ---------------------------------------------------------------------------
module tb_crypto_round_sequencer;

  localparam int W = 32;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         start = 1'b0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         sel = 1'b0;
  logic         ready;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] core_rs1;
  logic [W-1:0] core_rs2;
  logic [1:0]   core_count;
  logic         core_sel;
  logic [W-1:0] core_rd;
  logic [1:0]   dbg_state_o;
`ifdef CRYPTO_ABORT_EN
  logic         abort = 1'b0;
`endif

  assign core_rd = (core_rs1 ^ core_rs2) + {30'b0, core_count};

  crypto_round_sequencer #(.NUM_ROUNDS(4), .DATA_W(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .rs1          (rs1),
    .rs2          (rs2),
    .sel          (sel),
`ifdef CRYPTO_ABORT_EN
    .abort        (abort),
`endif
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .core_rs1     (core_rs1),
    .core_rs2     (core_rs2),
    .core_count   (core_count),
    .core_sel     (core_sel),
    .core_rd      (core_rd),
    .dbg_state_o  (dbg_state_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference: four rounds of the stub core
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] k,
                                         input logic s);
    logic [W-1:0] d;
    logic [1:0]   c;
    d = a;
    for (int r = 0; r < 4; r++) begin
      c = s ? 2'(3 - r) : 2'(r);
      d = (d ^ k) + {30'b0, c};
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [W-1:0] obs);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=<empty queue>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // driver: advance one clock, land 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [W-1:0] enc_rs1 [4];
  logic [W-1:0] dec_rs1 [4];
  logic [1:0]   enc_cnt [4];
  logic [1:0]   dec_cnt [4];
  logic [W-1:0] held;
  int           acc_t[$];

  initial begin
    enc_rs1 = '{32'h0, 32'hFF, 32'h1, 32'h100};
    enc_cnt = '{2'd0, 2'd1, 2'd2, 2'd3};
    dec_rs1 = '{32'h0, 32'h102, 32'h1FF, 32'h101};
    dec_cnt = '{2'd3, 2'd2, 2'd1, 2'd0};

    // ---- 1. reset, released between edges ----
    #12;
    check("rst_ready",  32'(ready), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_valid",  32'(result_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_count",  32'(core_count), 32'd0);
    check("rst_state",  32'(dbg_state_o), 32'd0);
    RST = 1'b0;
    step();
    check("idle_ready", 32'(ready), 32'd1);

    // ---- 2. encrypt ----
    rs1 = 32'h0; rs2 = 32'hFF; sel = 1'b0; start = 1'b1;
    exp_q.push_back(model(rs1, rs2, sel));
    step();
    start = 1'b0;
    check("enc_busy",  32'(busy), 32'd1);
    check("enc_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("enc_cnt%0d", i), 32'(core_count), 32'(enc_cnt[i]));
      check($sformatf("enc_rs1_%0d", i), core_rs1, enc_rs1[i]);
      check($sformatf("enc_novalid%0d", i), 32'(result_valid), 32'd0);
      step();
    end
    check("enc_valid", 32'(result_valid), 32'd1);
    check("enc_const", result, 32'h202);
    sb_check("enc_result", result);
    check("enc_done_state", 32'(dbg_state_o), 32'd2);
    check("enc_cnt_hold", 32'(core_count), 32'd3);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("enc_ready_back", 32'(ready), 32'd1);
    check("enc_valid_drop", 32'(result_valid), 32'd0);
    check("enc_result_hold", result, 32'h202);

    // ---- 3. decrypt, result held under back-pressure ----
    rs1 = 32'h0; rs2 = 32'hFF; sel = 1'b1; start = 1'b1;
    exp_q.push_back(model(rs1, rs2, sel));
    step();
    start = 1'b0;
    check("dec_core_sel", 32'(core_sel), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dec_cnt%0d", i), 32'(core_count), 32'(dec_cnt[i]));
      check($sformatf("dec_rs1_%0d", i), core_rs1, dec_rs1[i]);
      step();
    end
    check("dec_valid", 32'(result_valid), 32'd1);
    check("dec_const", result, 32'h1FE);
    sb_check("dec_result", result);
    held = result;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("dec_hold_valid%0d", i), 32'(result_valid), 32'd1);
      check($sformatf("dec_hold_result%0d", i), result, held);
      check($sformatf("dec_hold_ready%0d", i), 32'(ready), 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("dec_ready_back", 32'(ready), 32'd1);

    // ---- 4. back-to-back with start held high ----
    for (int c = 0; c < 14; c++) begin
      rs1 = $urandom; rs2 = $urandom; sel = 1'($urandom_range(0, 1));
      start = 1'b1;
      result_ready = 1'b1;
      if (ready) begin
        exp_q.push_back(model(rs1, rs2, sel));
        acc_t.push_back(c);
      end
      if (result_valid) sb_check($sformatf("b2b_result_c%0d", c), result);
      step();
    end
    start = 1'b0;
    for (int c = 14; c < 24; c++) begin
      if (result_valid) sb_check($sformatf("b2b_result_c%0d", c), result);
      step();
    end
    result_ready = 1'b0;
    check("b2b_accepts", 32'(acc_t.size()), 32'd3);
    if (acc_t.size() == 3) begin
      check("b2b_interval1", 32'(acc_t[1] - acc_t[0]), 32'd6);
      check("b2b_interval2", 32'(acc_t[2] - acc_t[1]), 32'd6);
    end
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---- 5. reset during round 2 ----
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; sel = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("mid_cnt_before_rst", 32'(core_count), 32'd2);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_ready",  32'(ready), 32'd1);
    check("mid_rst_busy",   32'(busy), 32'd0);
    check("mid_rst_valid",  32'(result_valid), 32'd0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_count",  32'(core_count), 32'd0);
    check("mid_rst_rs1",    core_rs1, 32'h0);
    #2 RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("mid_novalid%0d", i), 32'(result_valid), 32'd0);
      check($sformatf("mid_result%0d", i), result, 32'h0);
    end

`ifdef CRYPTO_ABORT_EN
    // ---- 6. abort during round 1, then restart ----
    rs1 = 32'h0; rs2 = 32'hFF; sel = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abt_round1_cnt", 32'(core_count), 32'd1);
    abort = 1'b1;
    step();
    check("abt_ready",  32'(ready), 32'd1);
    check("abt_valid",  32'(result_valid), 32'd0);
    check("abt_result", result, 32'h0);
    // abort still high in IDLE must not block this start
    start = 1'b1;
    exp_q.push_back(model(rs1, rs2, sel));
    step();
    start = 1'b0;
    abort = 1'b0;
    check("abt_restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abt_novalid%0d", i), 32'(result_valid), 32'd0);
      step();
    end
    check("abt_valid_final", 32'(result_valid), 32'd1);
    check("abt_const", result, 32'h202);
    sb_check("abt_result", result);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("abt_ready_back", 32'(ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
